alu_frame_ctrl: RTL

Command framer and ALU stage between the UART receiver and transmitter. It collects three received bytes in order (operand A, operand B, opcode) and computes the ALU result. It presents the result to the UART TX path with a one-cycle valid pulse, then waits for TX completion before accepting the next frame. Malformed or stalled frames are recovered by opcode checking and an inter-byte timeout.

---
 rtl/alu_frame_pkg.sv | 32 +++
 rtl/alu_core.sv | 54 +++++
 rtl/alu_frame_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_frame_pkg.sv
// rtl/alu_frame_pkg.sv - opcodes, FSM states and status bit indices for alu_frame_ctrl
package alu_frame_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [OP_W-1:0] OP_NOR = 6'h27;
    localparam logic [OP_W-1:0] OP_SRL = 6'h02;
    localparam logic [OP_W-1:0] OP_SRA = 6'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX,
        ST_SEND_STAT,
        ST_WAIT_TX2
    } state_t;

    localparam int STAT_W     = 4;
    localparam int STAT_ZERO  = 0;
    localparam int STAT_CARRY = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_MSB   = 3;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU; status flags exist only with ALU_FRAME_STATUS_EN
module alu_core
    import alu_frame_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] result,
    output logic               op_ok
`ifdef ALU_FRAME_STATUS_EN
    ,
    output logic [STAT_W-1:0]  flags
`endif
);

    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    always_comb begin
        result = '0;
        op_ok  = 1'b1;
        case (op)
            NB_OP'(OP_ADD): result = a + b;
            NB_OP'(OP_SUB): result = a - b;
            NB_OP'(OP_AND): result = a & b;
            NB_OP'(OP_OR):  result = a | b;
            NB_OP'(OP_XOR): result = a ^ b;
            NB_OP'(OP_NOR): result = ~(a | b);
            NB_OP'(OP_SRL): result = (b >= SHIFT_LIM) ? '0 : (a >> b);
            // Oversized arithmetic shifts saturate to a fill of the sign bit
            NB_OP'(OP_SRA): result = (b >= SHIFT_LIM) ? {NB_DATA{a[NB_DATA-1]}}
                                                      : $unsigned($signed(a) >>> b);
            default:        op_ok = 1'b0;
        endcase
    end

`ifdef ALU_FRAME_STATUS_EN
    always_comb begin
        flags            = '0;
        flags[STAT_ZERO] = (result == '0);
        flags[STAT_MSB]  = result[NB_DATA-1];
        if (op == NB_OP'(OP_ADD)) begin
            flags[STAT_CARRY] = (result < a);
            flags[STAT_OVF]   = (a[NB_DATA-1] == b[NB_DATA-1]) && (result[NB_DATA-1] != a[NB_DATA-1]);
        end else if (op == NB_OP'(OP_SUB)) begin
            flags[STAT_CARRY] = (a >= b);
            flags[STAT_OVF]   = (a[NB_DATA-1] != b[NB_DATA-1]) && (result[NB_DATA-1] != a[NB_DATA-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_frame_ctrl.sv
// rtl/alu_frame_ctrl.sv - three-byte command framer and ALU stage; ALU_FRAME_STATUS_EN adds a status byte
module alu_frame_ctrl
    import alu_frame_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_dato,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_error,
    output logic               o_overrun
);

    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    state_t              state, state_n;
    logic [NB_DATA-1:0]  a_q, b_q, result_q, core_result;
    logic [NB_OP-1:0]    op_q;
    logic [NB_CNT-1:0]   cnt_q;
    logic                core_ok, error_q, overrun_q;
    logic                accept, expire, drop, in_wait;
    logic                unused_dato_hi;

    assign unused_dato_hi = ^i_dato;

`ifdef ALU_FRAME_STATUS_EN
    logic [STAT_W-1:0]   core_flags;
    logic [NB_DATA-1:0]  status_byte;
    assign status_byte = {{(NB_DATA-STAT_W){1'b0}}, core_flags};
`endif

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .op_ok  (core_ok)
`ifdef ALU_FRAME_STATUS_EN
        ,
        .flags  (core_flags)
`endif
    );

    assign in_wait = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        expire  = 1'b0;
        drop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    state_n = ST_WAIT_B;
                end
            end
            // A byte landing on the expiry cycle wins over the timeout
            ST_WAIT_B, ST_WAIT_OP: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    state_n = (state == ST_WAIT_B) ? ST_WAIT_OP : ST_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_EXEC: begin
                drop    = i_valid;
                state_n = core_ok ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                drop    = i_valid;
                state_n = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                drop = i_valid;
                if (i_tx_done) begin
`ifdef ALU_FRAME_STATUS_EN
                    state_n = ST_SEND_STAT;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef ALU_FRAME_STATUS_EN
            ST_SEND_STAT: begin
                drop    = i_valid;
                state_n = ST_WAIT_TX2;
            end
            ST_WAIT_TX2: begin
                drop = i_valid;
                if (i_tx_done) state_n = ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            error_q   <= expire || ((state == ST_EXEC) && !core_ok);
            overrun_q <= drop;
            if (accept || !in_wait) cnt_q <= '0;
            else                    cnt_q <= cnt_q + 1'b1;
            if (accept) begin
                case (state)
                    ST_IDLE:    a_q  <= i_dato;
                    ST_WAIT_B:  b_q  <= i_dato;
                    ST_WAIT_OP: op_q <= i_dato[NB_OP-1:0];
                    default:    ;
                endcase
            end
            if ((state == ST_EXEC) && core_ok) result_q <= core_result;
`ifdef ALU_FRAME_STATUS_EN
            // Operands are still held, so the flags describe the frame just sent
            if ((state == ST_WAIT_TX) && i_tx_done) result_q <= status_byte;
`endif
        end
    end

    assign o_result  = result_q;
    assign o_valid   = (state == ST_SEND) || (state == ST_SEND_STAT);
    assign o_busy    = (state != ST_IDLE);
    assign o_error   = error_q;
    assign o_overrun = overrun_q;

endmodule
